// File: rtl/fetch_unit_hs.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack memory handshake and
// hands {instr, pc, pc_plus} to decode through a one-entry valid/ready buffer.
module fetch_unit_hs #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 16,
    parameter int              PC_INC   = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'b00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_plus,
    output logic              halted,
    output logic [1:0]        state_dbg
);

    // Handshakes: memory side transfers when mem_req && mem_ack; decode side transfers
    // when out_valid && out_ready. A redirect cancels both transfers in its cycle.
    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_FULL   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc;
    logic            halt_seen;
    logic            is_halt;

    assign is_halt   = (mem_rdata[DATA_W-1 -: 5] == HALT_OP);
    assign mem_addr  = pc;
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        halted  = 1'b0;
        case (state_q)
            S_REQ: begin
                mem_req = !rst;
                if (mem_ack) state_d = S_FULL;
            end
            S_FULL: begin
                if (out_ready) state_d = halt_seen ? S_HALTED : S_REQ;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) state_d = S_REQ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            out_pc_plus <= '0;
            halt_seen   <= 1'b0;
        end else if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            halt_seen <= 1'b0;
        end else begin
            if (state_q == S_REQ && mem_ack) begin
                out_instr   <= mem_rdata;
                out_pc      <= pc;
                out_pc_plus <= pc + INC;
                out_valid   <= 1'b1;
                pc          <= pc + INC;
                halt_seen   <= is_halt;
            end
            if (state_q == S_FULL && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit_hs.sv
// Self-checking bench for fetch_unit_hs: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural fetch model.
module tb_fetch_unit_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_plus;
    logic        halted;
    logic [1:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    fetch_unit_hs dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus(out_pc_plus),
        .halted(halted), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a fetch pointer, an optional buffered entry, a halted flag.
    logic [15:0] m_pc = '0;
    logic        m_buf_valid = 1'b0;
    logic [15:0] m_instr = '0;
    logic [15:0] m_bpc = '0;
    logic        m_halted = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 16'h0000;
            m_buf_valid <= 1'b0;
            m_halted <= 1'b0;
        end else if (redirect_valid) begin
            m_pc <= redirect_pc;
            m_buf_valid <= 1'b0;
            m_halted <= 1'b0;
        end else if (m_halted) begin
            m_halted <= 1'b1;
        end else if (m_buf_valid) begin
            if (out_ready) begin
                m_buf_valid <= 1'b0;
                if (m_instr[15:11] == 5'b00000) m_halted <= 1'b1;
            end
        end else if (mem_ack) begin
            m_instr <= mem_rdata;
            m_bpc <= m_pc;
            m_pc <= m_pc + 16'd2;
            m_buf_valid <= 1'b1;
        end
    end

    function automatic logic model_req();
        return !m_halted && !m_buf_valid;
    endfunction

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            logic        exp_req;
            logic [15:0] exp_plus;
            exp_req  = !rst && model_req();
            exp_plus = m_bpc + 16'd2;
            check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
            if (exp_req) check("mem_addr", {16'd0, mem_addr}, {16'd0, m_pc});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_buf_valid});
            if (m_buf_valid) begin
                check("out_instr", {16'd0, out_instr}, {16'd0, m_instr});
                check("out_pc", {16'd0, out_pc}, {16'd0, m_bpc});
                check("out_pc_plus", {16'd0, out_pc_plus}, {16'd0, exp_plus});
            end
            check("halted", {31'd0, halted}, {31'd0, m_halted});
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic ack_now(input logic [15:0] data);
        mem_ack = 1'b1;
        mem_rdata = data;
        step();
        mem_ack = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // reset and back-to-back fetches with same-cycle ack
        step();
        chk_en = 1'b1;
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pc", {16'd0, out_pc}, 32'h0);
        check("rst_out_instr", {16'd0, out_instr}, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        #1;
        check("t1_addr0", {15'd0, mem_req, mem_addr}, 32'h1_0000);
        ack_now(16'h1234);
        check("t1_instr0", {16'd0, out_instr}, 32'h1234);
        check("t1_pc0", {out_pc, out_pc_plus}, 32'h0000_0002);
        pop();
        check("t1_addr1", {15'd0, mem_req, mem_addr}, 32'h1_0002);
        ack_now(16'h5678);
        check("t1_pc1", {out_pc, out_pc_plus}, 32'h0002_0004);

        // backpressure holds the entry and stalls fetching
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold", {14'd0, out_valid, mem_req, out_instr}, 32'h2_5678);
        end
        pop();
        check("t3_next", {15'd0, mem_req, mem_addr}, 32'h1_0004);

        // delayed ack: request held for four cycles
        do_redirect(16'h0000);
        for (int i = 0; i < 4; i++) begin
            check("t2_wait", {15'd0, mem_req, mem_addr}, 32'h1_0000);
            if (i == 3) ack_now(16'hABCD);
            else step();
        end
        check("t2_data", {15'd0, out_valid, out_instr}, 32'h1_ABCD);

        // redirect while full drops the entry even with out_ready high
        out_ready = 1'b1;
        do_redirect(16'h0100);
        out_ready = 1'b0;
        check("t4_drop", {14'd0, out_valid, mem_req, mem_addr}, 32'h1_0100);
        ack_now(16'h1111);
        check("t4_pc", {16'd0, out_pc}, 32'h0100);
        pop();

        // halt delivered at pc 6, then fetch stops until redirect
        do_redirect(16'h0006);
        ack_now(16'h0000);
        check("t5_deliver", {14'd0, out_valid, halted, out_pc}, 32'h2_0006);
        pop();
        for (int i = 0; i < 5; i++) begin
            check("t5_halted", {29'd0, halted, mem_req, out_valid}, 32'd4);
            step();
        end
        do_redirect(16'h0000);
        check("t5_resume", {14'd0, halted, mem_req, mem_addr}, 32'h1_0000);

        // PC wrap
        do_redirect(16'hFFFE);
        ack_now(16'h2222);
        check("t6_wrap", {out_pc, out_pc_plus}, 32'hFFFE_0000);
        pop();
        check("t6_next", {15'd0, mem_req, mem_addr}, 32'h1_0000);

        // reset in the middle of a pending request
        do_redirect(16'h0040);
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_req", {31'd0, mem_req}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("t6_rst_fetch", {15'd0, mem_req, mem_addr}, 32'h1_0000);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 16'hFFFE;
                1:       redirect_pc = 16'($urandom_range(0, 65535));
                default: redirect_pc = 16'($urandom_range(0, 127)) << 1;
            endcase
            mem_ack = !rst && model_req() && ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) mem_rdata[15:11] = 5'b00000;
            out_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        mem_ack = 1'b0;
        step();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
